audio_gain_stage: RTL and testbench
===================================

Name: audio_gain_stage

Overview:
- Streaming stereo gain/mute stage between the host playback write stream and the playback FIFO write port of the I2S block.
- Input and output words use the same stereo format: left = [31:16], right = [15:0], signed 16-bit two's complement.
- Per-channel gain is Q2.14 unsigned and ramps toward a target per accepted word, so gain changes are free of zipper noise.
- Output samples are rounded and saturated; saturated samples are counted.

Parameters:
- RAMP_STEP, 16'h0400: gain increment/decrement applied per accepted input word.
- RESET_GAIN, 16'h0000: value of both current gains after reset (0 = fade-in after reset).

Ports:
- bus_clk  in  1  sole clock.
- quiesce  in  1  reset, synchronous, active-high.
- in_wren  in  1  input word valid. The upstream asserts it only while in_full=0.
- in_data  in  32  stereo input word.
- in_full  out  1  backpressure to upstream. Combinational: equals stall.
- out_wren  out  1  write strobe to the playback FIFO.
- out_data  out  32  processed stereo word.
- out_full  in  1  playback FIFO full.
- gain_l  in  16  left target gain, Q2.14 (16'h4000 = unity).
- gain_r  in  16  right target gain, Q2.14.
- mute  in  1  while 1, both targets are forced to 0. Ramping applies as usual.
- clip_clear  in  1  clears clip_count.
- clip_count  out  16  saturating count of clipped output samples (each channel counted separately).

Behaviour:
- Reset (quiesce=1), effective next edge:
  - S1/S2/S3 valid bits = 0.
  - cur_l = cur_r = RESET_GAIN.
  - clip_count = 0.
  - out_wren = 0 and in_full = 0 in the cycle after reset.
  - Words in flight are dropped. Reset in mid-stream therefore loses up to 3 words; this is required behaviour.
- Stall:
  - stall = S3.valid & out_full.
  - out_wren = S3.valid & ~out_full, so the block never writes while the FIFO is full.
  - While stall=1, all stages hold and in_full = 1.
- Pipeline, advancing when stall=0:
  - S1: capture in_data and snapshot (cur_l, cur_r); valid = in_wren.
  - S2: signed 16 x unsigned 16 multiply per channel into 33-bit signed products.
  - S3: add 2^13, arithmetic shift right by 14, saturate to [-32768, 32767], pack to out_data.
  - Latency: in_wren to out_wren = 3 cycles when there is no stall.
  - Throughput: 1 word per cycle.
- Gain ramp, per channel, updated only on cycles with in_wren & ~stall:
  - If cur < tgt: cur = min(cur + RAMP_STEP, tgt).
  - If cur > tgt: cur = max(cur - RAMP_STEP, tgt).
  - Otherwise cur holds.
  - The word accepted in a cycle uses cur from before that cycle's update.
  - Arithmetic is 17-bit so there is no wrap at 16'hFFFF or 0.
  - tgt = mute ? 0 : gain_x.
  - A target change mid-ramp takes effect at the next accepted word.
  - RAMP_STEP = 0 freezes the gain.
- Clipping:
  - Each S3 channel whose value was saturated adds 1 to clip_count on the S3 advance, i.e. when out_wren=1.
  - A word clipping both channels adds 2 in one cycle.
  - clip_count saturates at 16'hFFFF.
  - clip_clear has priority over increments in the same cycle.
- in_wren while in_full=1 is a protocol violation by the upstream. The word is ignored and the gain does not ramp.

Decomposition:
- Shared package audio_pkg:
  - GAIN_W=16, GAIN_FRAC=14, UNITY_GAIN=16'h4000, SAMPLE_W=16.
  - SAMPLE_MAX/SAMPLE_MIN.
  - Stereo slice constants (L_MSB=31, L_LSB=16, R_MSB=15, R_LSB=0).
- Sub-module audio_gain_chan: one channel holding the ramp register, multiply, round/saturate and clip flag. Instantiated twice; stall and accept enables come from the top.
- The top owns the valid bits, handshake logic and clip_count.

Test Plan:
- Unity pass-through:
  - Setup: RESET_GAIN=16'h4000, gain_l=gain_r=16'h4000, out_full=0.
  - Stimulus: words 32'h7FFF_8000, 32'h1234_FEDC.
  - Response: identical words on out_wren exactly 3 cycles after each in_wren; clip_count=0.
- Half gain and rounding:
  - Stimulus: gain=16'h2000, input L=16'h0003, R=16'hFFFD.
  - Response: L=16'h0002, R=16'hFFFF (-3*0.5 = -1.5, +0.5 then floor = -1).
- Saturation:
  - Stimulus: gain=16'h8000, input 32'h7000_9000.
  - Response: output 32'h7FFF_8000; clip_count=2. Pulsing clip_clear gives clip_count=0.
- Ramp:
  - Stimulus: reset with RESET_GAIN=0, gain_l=16'h4000, input L=16'h4000 constant, 17 words.
  - Response: outputs L = 0, 16'h0400, 16'h0800, …, 16'h4000 (16th onward); the gain holds at the target.
  - Then mute=1: L ramps down by 16'h0400 per word to 0.
- Backpressure:
  - Stimulus: hold out_full=1 for 5 cycles while a 6-word burst is in progress.
  - Response: out_wren=0 and in_full=1 throughout; no word lost or duplicated; order preserved; the ramp does not advance while stalled.
- Reset mid-stream:
  - Stimulus: assert quiesce one cycle with 3 words in flight.
  - Response: out_wren=0 on the next cycle; those words are never emitted; cur gains = RESET_GAIN; the next accepted word emerges 3 cycles after in_wren.

Source files
------------

// File: rtl/audio_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | audio_pkg                                                                  |
// | Shared widths, sample limits, stereo slices and the gain-ramp helper.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package audio_pkg;

  localparam int GAIN_W     = 16;
  localparam int GAIN_FRAC  = 14;
  localparam int SAMPLE_W   = 16;
  localparam int PROD_W     = SAMPLE_W + GAIN_W + 1;
  localparam logic [GAIN_W-1:0] UNITY_GAIN = 16'h4000;

  localparam int SAMPLE_MAX = 32767;
  localparam int SAMPLE_MIN = -32768;

  localparam int L_MSB = 31;
  localparam int L_LSB = 16;
  localparam int R_MSB = 15;
  localparam int R_LSB = 0;

  // One ramp step toward the target, clamped so it never overshoots or wraps.
  function automatic logic [GAIN_W-1:0] ramp_next(
    input logic [GAIN_W-1:0] cur,
    input logic [GAIN_W-1:0] tgt,
    input logic [GAIN_W-1:0] step
  );
    logic [GAIN_W:0] up;
    logic [GAIN_W:0] dn;
    up        = {1'b0, cur} + {1'b0, step};
    dn        = {1'b0, cur} - {1'b0, step};
    ramp_next = cur;
    if (cur < tgt) begin
      ramp_next = (up > {1'b0, tgt}) ? tgt : up[GAIN_W-1:0];
    end else if (cur > tgt) begin
      ramp_next = (dn[GAIN_W] || (dn[GAIN_W-1:0] < tgt)) ? tgt : dn[GAIN_W-1:0];
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/audio_gain_chan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | audio_gain_chan                                                            |
// | One channel: gain ramp register, multiply, round, saturate, clip flag.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module audio_gain_chan
  import audio_pkg::*;
#(
  parameter logic [GAIN_W-1:0] RAMP_STEP  = 16'h0400,
  parameter logic [GAIN_W-1:0] RESET_GAIN = 16'h0000
) (
  input  logic                bus_clk,
  input  logic                quiesce,
  input  logic                advance,
  input  logic                accept,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic [GAIN_W-1:0]   target,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                clipped
);

  localparam logic signed [PROD_W-1:0] c_round    = PROD_W'(1 << (GAIN_FRAC - 1));
  localparam logic signed [PROD_W-1:0] c_prod_max = PROD_W'(SAMPLE_MAX);
  localparam logic signed [PROD_W-1:0] c_prod_min = PROD_W'(SAMPLE_MIN);

  logic [GAIN_W-1:0]          r_cur_gain;
  logic [SAMPLE_W-1:0]        r_s1_sample;
  logic [GAIN_W-1:0]          r_s1_gain;
  logic signed [PROD_W-1:0]   r_s2_prod;
  logic [SAMPLE_W-1:0]        r_s3_sample;
  logic                       r_s3_clip;

  logic signed [PROD_W-1:0]   w_samp_ext;
  logic signed [PROD_W-1:0]   w_gain_ext;
  logic signed [PROD_W-1:0]   w_rounded;
  logic [SAMPLE_W-1:0]        w_sat;
  logic                       w_clip;

  assign w_samp_ext = {{(PROD_W-SAMPLE_W){r_s1_sample[SAMPLE_W-1]}}, r_s1_sample};
  assign w_gain_ext = {{(PROD_W-GAIN_W){1'b0}}, r_s1_gain};
  assign w_rounded  = (r_s2_prod + c_round) >>> GAIN_FRAC;

  always_comb begin
    w_sat  = w_rounded[SAMPLE_W-1:0];
    w_clip = 1'b0;
    if (w_rounded > c_prod_max) begin
      w_sat  = c_prod_max[SAMPLE_W-1:0];
      w_clip = 1'b1;
    end else if (w_rounded < c_prod_min) begin
      w_sat  = c_prod_min[SAMPLE_W-1:0];
      w_clip = 1'b1;
    end
  end

  // The accepted word snapshots the gain before this cycle's ramp update.
  always_ff @(posedge bus_clk) begin
    if (quiesce) begin
      r_cur_gain <= RESET_GAIN;
    end else if (accept) begin
      r_cur_gain <= ramp_next(r_cur_gain, target, RAMP_STEP);
    end
  end

  always_ff @(posedge bus_clk) begin
    if (quiesce) begin
      r_s1_sample <= '0;
      r_s1_gain   <= '0;
      r_s2_prod   <= '0;
      r_s3_sample <= '0;
      r_s3_clip   <= 1'b0;
    end else if (advance) begin
      r_s1_sample <= sample_in;
      r_s1_gain   <= r_cur_gain;
      r_s2_prod   <= w_samp_ext * w_gain_ext;
      r_s3_sample <= w_sat;
      r_s3_clip   <= w_clip;
    end
  end

  assign sample_out = r_s3_sample;
  assign clipped    = r_s3_clip;

endmodule
`default_nettype wire

// File: rtl/audio_gain_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | audio_gain_stage                                                           |
// | Stereo gain/mute stage with ramped gains, saturation and clip counting.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module audio_gain_stage
  import audio_pkg::*;
#(
  parameter logic [GAIN_W-1:0] RAMP_STEP  = 16'h0400,
  parameter logic [GAIN_W-1:0] RESET_GAIN = 16'h0000
) (
  input  logic                bus_clk,
  input  logic                quiesce,
  input  logic                in_wren,
  input  logic [31:0]         in_data,
  output logic                in_full,
  output logic                out_wren,
  output logic [31:0]         out_data,
  input  logic                out_full,
  input  logic [GAIN_W-1:0]   gain_l,
  input  logic [GAIN_W-1:0]   gain_r,
  input  logic                mute,
  input  logic                clip_clear,
  output logic [15:0]         clip_count
);

  logic        r_s1_valid;
  logic        r_s2_valid;
  logic        r_s3_valid;
  logic [15:0] r_clip_count;

  logic              w_stall;
  logic              w_advance;
  logic              w_accept;
  logic [GAIN_W-1:0] w_tgt_l;
  logic [GAIN_W-1:0] w_tgt_r;
  logic              w_clip_l;
  logic              w_clip_r;
  logic [1:0]        w_clip_inc;
  logic [16:0]       w_clip_sum;

  assign w_stall   = r_s3_valid & out_full;
  assign w_advance = ~w_stall;
  assign w_accept  = in_wren & ~w_stall;
  assign in_full   = w_stall;
  assign out_wren  = r_s3_valid & ~out_full;

  assign w_tgt_l = mute ? '0 : gain_l;
  assign w_tgt_r = mute ? '0 : gain_r;

  always_ff @(posedge bus_clk) begin
    if (quiesce) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s3_valid <= 1'b0;
    end else if (w_advance) begin
      r_s1_valid <= in_wren;
      r_s2_valid <= r_s1_valid;
      r_s3_valid <= r_s2_valid;
    end
  end

  audio_gain_chan #(
    .RAMP_STEP  (RAMP_STEP),
    .RESET_GAIN (RESET_GAIN)
  ) u_chan_l (
    .bus_clk    (bus_clk),
    .quiesce    (quiesce),
    .advance    (w_advance),
    .accept     (w_accept),
    .sample_in  (in_data[L_MSB:L_LSB]),
    .target     (w_tgt_l),
    .sample_out (out_data[L_MSB:L_LSB]),
    .clipped    (w_clip_l)
  );

  audio_gain_chan #(
    .RAMP_STEP  (RAMP_STEP),
    .RESET_GAIN (RESET_GAIN)
  ) u_chan_r (
    .bus_clk    (bus_clk),
    .quiesce    (quiesce),
    .advance    (w_advance),
    .accept     (w_accept),
    .sample_in  (in_data[R_MSB:R_LSB]),
    .target     (w_tgt_r),
    .sample_out (out_data[R_MSB:R_LSB]),
    .clipped    (w_clip_r)
  );

  // Clips count only when the word actually leaves S3.
  assign w_clip_inc = {1'b0, w_clip_l & out_wren} + {1'b0, w_clip_r & out_wren};
  assign w_clip_sum = {1'b0, r_clip_count} + {15'd0, w_clip_inc};

  always_ff @(posedge bus_clk) begin
    if (quiesce || clip_clear) begin
      r_clip_count <= '0;
    end else if (w_clip_sum[16]) begin
      r_clip_count <= 16'hFFFF;
    end else begin
      r_clip_count <= w_clip_sum[15:0];
    end
  end

  assign clip_count = r_clip_count;

endmodule
`default_nettype wire

// File: tb/tb_audio_gain_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_audio_gain_stage                                                        |
// | Directed-vector bench: ramp, mute, unity, rounding, clip, stall, reset.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_audio_gain_stage;

  logic        bus_clk = 1'b0;
  logic        quiesce;
  logic        in_wren;
  logic [31:0] in_data;
  logic        in_full;
  logic        out_wren;
  logic [31:0] out_data;
  logic        out_full;
  logic [15:0] gain_l;
  logic [15:0] gain_r;
  logic        mute;
  logic        clip_clear;
  logic [15:0] clip_count;

  int          n_vec  = 0;
  int          n_miss = 0;
  int          cyc    = 0;
  logic [31:0] out_q[$];
  int          out_cyc_q[$];
  int          acc_cyc_q[$];

  audio_gain_stage #(
    .RAMP_STEP  (16'h0400),
    .RESET_GAIN (16'h0000)
  ) dut (
    .bus_clk    (bus_clk),
    .quiesce    (quiesce),
    .in_wren    (in_wren),
    .in_data    (in_data),
    .in_full    (in_full),
    .out_wren   (out_wren),
    .out_data   (out_data),
    .out_full   (out_full),
    .gain_l     (gain_l),
    .gain_r     (gain_r),
    .mute       (mute),
    .clip_clear (clip_clear),
    .clip_count (clip_count)
  );

  always #5 bus_clk = ~bus_clk;

  always @(posedge bus_clk) cyc <= cyc + 1;

  always @(negedge bus_clk) begin
    if (out_wren) begin
      out_q.push_back(out_data);
      out_cyc_q.push_back(cyc);
    end
    if (in_wren && !in_full && !quiesce) acc_cyc_q.push_back(cyc);
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge bus_clk);
    #1;
  endtask

  task automatic pump(input int n, input logic [31:0] d);
    for (int i = 0; i < n; i++) begin
      in_wren = 1'b1;
      in_data = d;
      tick();
    end
    in_wren = 1'b0;
  endtask

  task automatic drain();
    repeat (6) tick();
  endtask

  task automatic clear_q();
    out_q.delete();
    out_cyc_q.delete();
    acc_cyc_q.delete();
  endtask

  task automatic check_out(input string tag, input int idx, input logic [31:0] exp);
    if (idx < out_q.size()) check_vec(tag, out_q[idx], exp);
    else check_vec({tag, "_missing"}, 32'hXXXX_XXXX, exp);
  endtask

  task automatic check_latency(input string tag, input int idx);
    if (idx < out_cyc_q.size() && idx < acc_cyc_q.size())
      check_vec(tag, 32'(out_cyc_q[idx] - acc_cyc_q[idx]), 32'd3);
    else
      check_vec({tag, "_missing"}, 32'hFFFF_FFFF, 32'd3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] e;
    logic        full_seen;
    int          k;
    int          c;

    quiesce = 1'b1; in_wren = 1'b0; in_data = '0; out_full = 1'b0;
    gain_l = 16'h4000; gain_r = 16'h4000; mute = 1'b0; clip_clear = 1'b0;
    repeat (3) tick();
    quiesce = 1'b0;
    check_vec("rst_out_wren", {31'd0, out_wren}, 32'd0);
    check_vec("rst_in_full", {31'd0, in_full}, 32'd0);
    check_vec("rst_clip", {16'd0, clip_count}, 32'd0);

    // Fade-in from zero gain: 17 words, L and R both step 0x400 per word.
    clear_q();
    pump(17, 32'h4000_4000);
    drain();
    check_vec("ramp_count", 32'(out_q.size()), 32'd17);
    for (int i = 0; i < 17; i++) begin
      e = (i >= 16) ? 16'h4000 : 16'(i * 16'h0400);
      check_out($sformatf("ramp_up%0d", i), i, {e, e});
    end

    mute = 1'b1;
    clear_q();
    pump(17, 32'h4000_4000);
    drain();
    for (int i = 0; i < 17; i++) begin
      e = (i >= 16) ? 16'h0000 : 16'(16'h4000 - i * 16'h0400);
      check_out($sformatf("ramp_mute%0d", i), i, {e, e});
    end
    mute = 1'b0;
    pump(16, 32'h0);
    drain();

    // Unity gain pass-through with latency check.
    clear_q();
    pump(1, 32'h7FFF_8000);
    pump(1, 32'h1234_FEDC);
    drain();
    check_out("unity0", 0, 32'h7FFF_8000);
    check_out("unity1", 1, 32'h1234_FEDC);
    check_latency("unity_lat0", 0);
    check_latency("unity_lat1", 1);
    check_vec("unity_clip", {16'd0, clip_count}, 32'd0);

    // Half gain: 8 words to ramp 0x4000 -> 0x2000.
    gain_l = 16'h2000; gain_r = 16'h2000;
    pump(8, 32'h0);
    drain();
    clear_q();
    pump(1, 32'h0003_FFFD);
    drain();
    check_out("half_round", 0, 32'h0002_FFFF);

    // Gain 2.0: 24 words to ramp 0x2000 -> 0x8000, then a word clipping both.
    gain_l = 16'h8000; gain_r = 16'h8000;
    pump(24, 32'h0);
    drain();
    check_vec("pre_sat_clip", {16'd0, clip_count}, 32'd0);
    clear_q();
    pump(1, 32'h7000_9000);
    drain();
    check_out("sat_word", 0, 32'h7FFF_8000);
    check_vec("sat_clip2", {16'd0, clip_count}, 32'd2);
    clip_clear = 1'b1;
    tick();
    clip_clear = 1'b0;
    check_vec("clip_cleared", {16'd0, clip_count}, 32'd0);

    // Backpressure: L ramps 0x8000 -> 0x4000, R stays at 0x8000 and tags order.
    gain_l = 16'h4000; gain_r = 16'h8000;
    clear_q();
    k = 0;
    c = 0;
    while (k < 6 && c < 40) begin
      out_full = (c >= 3 && c <= 7);
      #1;
      full_seen = in_full;
      in_wren = 1'b1;
      in_data = full_seen ? 32'hDEAD_BEEF : {16'h0100, 16'(k + 1)};
      if (c >= 3 && c <= 7) begin
        check_vec($sformatf("bp_in_full_c%0d", c), {31'd0, in_full}, 32'd1);
        check_vec($sformatf("bp_out_wren_c%0d", c), {31'd0, out_wren}, 32'd0);
      end
      @(posedge bus_clk);
      if (!full_seen) k++;
      #1;
      c++;
    end
    in_wren = 1'b0;
    out_full = 1'b0;
    check_vec("bp_all_sent", 32'(k), 32'd6);
    drain();
    check_vec("bp_count", 32'(out_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check_out($sformatf("bp_word%0d", i), i,
                {16'(16'h0200 - i * 16'h0010), 16'(2 * (i + 1))});
    end

    // Reset with three words held in the pipe by a full FIFO.
    clear_q();
    pump(3, 32'h1000_1000);
    out_full = 1'b1;
    tick();
    quiesce = 1'b1;
    tick();
    quiesce = 1'b0;
    out_full = 1'b0;
    check_vec("qrst_out_wren", {31'd0, out_wren}, 32'd0);
    check_vec("qrst_in_full", {31'd0, in_full}, 32'd0);
    check_vec("qrst_clip", {16'd0, clip_count}, 32'd0);
    acc_cyc_q.delete();
    pump(2, 32'h4000_4000);
    drain();
    check_vec("qrst_count", 32'(out_q.size()), 32'd2);
    check_out("qrst_word0", 0, 32'h0000_0000);
    check_out("qrst_word1", 1, 32'h0400_0400);
    check_latency("qrst_lat0", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
